// File: rtl/fmps_test_link_reader.sv
// Receive side of the FMPS test link (auroraUserClk domain).
// Parses header/payload beats from the Aurora RX stream, validates magic and length,
// emits registered packet/status strobes and keeps per-FA-cycle statistics.
module fmps_test_link_reader #(
    parameter int unsigned            MAGIC_WIDTH     = 16,
    parameter int unsigned            MAGIC_START_BIT = 16,
    parameter logic [MAGIC_WIDTH-1:0] HEADER_MAGIC    = 16'hB6CF,
    parameter int unsigned            INDEX_WIDTH     = 5,
    parameter int unsigned            INDEX_START_BIT = 10,
    parameter int unsigned            NUM_DATA_WORDS  = 1,
    parameter int unsigned            CNT_WIDTH       = 8
) (
    input  logic                          auroraUserClk,
    input  logic                          auroraReset,
    input  logic                          auroraChannelUp,
    input  logic                          auroraFAstrobe,
    input  logic [31:0]                   RX_tdata,
    input  logic                          RX_tvalid,
    input  logic                          RX_tlast,
    output logic                          packetStrobe,
    output logic [INDEX_WIDTH-1:0]        packetIndex,
    output logic [32*NUM_DATA_WORDS-1:0]  packetData,
    output logic                          statusStrobe,
    output logic [1:0]                    statusCode,
    output logic [CNT_WIDTH-1:0]          cycleGoodCount,
    output logic [CNT_WIDTH-1:0]          cycleErrCount,
    output logic [(2**INDEX_WIDTH)-1:0]   cycleIndexBitmap
);

    localparam int unsigned DATA_W   = 32 * NUM_DATA_WORDS;
    localparam int unsigned BITMAP_W = 2 ** INDEX_WIDTH;
    localparam int unsigned WC_W     = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_DATA_WORDS - 1);

    typedef enum logic [1:0] {
        S_HEADER = 2'd0,
        S_DATA   = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_BAD_MAGIC = 2'd1,
        ST_SHORT     = 2'd2,
        ST_LONG      = 2'd3
    } status_t;

    state_t                   state_q, state_d;
    logic [WC_W-1:0]          word_cnt_q, word_cnt_d;
    logic [INDEX_WIDTH-1:0]   hdr_index_q, hdr_index_d;
    logic [DATA_W-1:0]        buf_q, buf_d;

    logic                     pkt_strobe_q, pkt_strobe_d;
    logic [INDEX_WIDTH-1:0]   pkt_index_q, pkt_index_d;
    logic [DATA_W-1:0]        pkt_data_q, pkt_data_d;
    logic                     status_strobe_q, status_strobe_d;
    status_t                  status_code_q, status_code_d;

    logic [CNT_WIDTH-1:0]     live_good_q, live_good_d;
    logic [CNT_WIDTH-1:0]     live_err_q, live_err_d;
    logic [BITMAP_W-1:0]      live_bitmap_q, live_bitmap_d;
    logic [CNT_WIDTH-1:0]     cyc_good_q, cyc_good_d;
    logic [CNT_WIDTH-1:0]     cyc_err_q, cyc_err_d;
    logic [BITMAP_W-1:0]      cyc_bitmap_q, cyc_bitmap_d;

    logic                     beat;
    logic                     magic_ok;
    logic [INDEX_WIDTH-1:0]   rx_index;
    logic                     last_word;
    logic                     ev_done;
    status_t                  ev_code;
    logic                     ev_good;
    logic [CNT_WIDTH-1:0]     good_base;
    logic [CNT_WIDTH-1:0]     err_base;
    logic [BITMAP_W-1:0]      bitmap_base;

    // A beat only counts while the channel is up.
    assign beat      = auroraChannelUp & RX_tvalid;
    assign magic_ok  = (RX_tdata[MAGIC_START_BIT +: MAGIC_WIDTH] == HEADER_MAGIC);
    assign rx_index  = RX_tdata[INDEX_START_BIT +: INDEX_WIDTH];
    assign last_word = (word_cnt_q == LAST_WORD);

    // FSM state register.
    always_ff @(posedge auroraUserClk) begin
        if (auroraReset) begin
            state_q <= S_HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: packet framing; channel loss abandons any packet.
    always_comb begin
        state_d = state_q;
        if (!auroraChannelUp) begin
            state_d = S_HEADER;
        end else if (RX_tvalid) begin
            unique case (state_q)
                S_HEADER: begin
                    if (!magic_ok) begin
                        state_d = RX_tlast ? S_HEADER : S_DRAIN;
                    end else if (!RX_tlast) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (RX_tlast) begin
                        state_d = S_HEADER;
                    end else if (last_word) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (RX_tlast) begin
                        state_d = S_HEADER;
                    end
                end
                default: state_d = S_HEADER;
            endcase
        end
    end

    // Output logic: decide packet outcome, capture payload, update strobes and statistics.
    always_comb begin
        ev_done     = 1'b0;
        ev_code     = ST_OK;
        word_cnt_d  = word_cnt_q;
        hdr_index_d = hdr_index_q;
        buf_d       = buf_q;

        if (beat) begin
            unique case (state_q)
                S_HEADER: begin
                    hdr_index_d = rx_index;
                    word_cnt_d  = '0;
                    if (!magic_ok) begin
                        ev_done = 1'b1;
                        ev_code = ST_BAD_MAGIC;
                    end else if (RX_tlast) begin
                        ev_done = 1'b1;
                        ev_code = ST_SHORT;
                    end
                end
                S_DATA: begin
                    for (int unsigned w = 0; w < NUM_DATA_WORDS; w++) begin
                        if (word_cnt_q == WC_W'(w)) begin
                            buf_d[w*32 +: 32] = RX_tdata;
                        end
                    end
                    word_cnt_d = word_cnt_q + WC_W'(1);
                    if (RX_tlast) begin
                        ev_done = 1'b1;
                        ev_code = last_word ? ST_OK : ST_SHORT;
                    end else if (last_word) begin
                        ev_done = 1'b1;
                        ev_code = ST_LONG;
                    end
                end
                S_DRAIN: ;
                default: ;
            endcase
        end

        ev_good = ev_done && (ev_code == ST_OK);

        pkt_strobe_d    = ev_good;
        status_strobe_d = ev_done;
        status_code_d   = ev_done ? ev_code : status_code_q;
        pkt_index_d     = ev_good ? hdr_index_q : pkt_index_q;
        // buf_d already contains the final word written this beat.
        pkt_data_d      = ev_good ? buf_d : pkt_data_q;

        // An FA strobe rolls live stats into the cycle outputs; an event decided in the
        // same cycle is then applied on top of the cleared live values.
        cyc_good_d   = auroraFAstrobe ? live_good_q   : cyc_good_q;
        cyc_err_d    = auroraFAstrobe ? live_err_q    : cyc_err_q;
        cyc_bitmap_d = auroraFAstrobe ? live_bitmap_q : cyc_bitmap_q;
        good_base    = auroraFAstrobe ? '0 : live_good_q;
        err_base     = auroraFAstrobe ? '0 : live_err_q;
        bitmap_base  = auroraFAstrobe ? '0 : live_bitmap_q;

        live_good_d   = good_base;
        live_err_d    = err_base;
        live_bitmap_d = bitmap_base;
        if (ev_good) begin
            live_bitmap_d[hdr_index_q] = 1'b1;
            if (good_base != '1) begin
                live_good_d = good_base + CNT_WIDTH'(1);
            end
        end else if (ev_done) begin
            if (err_base != '1) begin
                live_err_d = err_base + CNT_WIDTH'(1);
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge auroraUserClk) begin
        if (auroraReset) begin
            word_cnt_q      <= '0;
            hdr_index_q     <= '0;
            buf_q           <= '0;
            pkt_strobe_q    <= 1'b0;
            pkt_index_q     <= '0;
            pkt_data_q      <= '0;
            status_strobe_q <= 1'b0;
            status_code_q   <= ST_OK;
            live_good_q     <= '0;
            live_err_q      <= '0;
            live_bitmap_q   <= '0;
            cyc_good_q      <= '0;
            cyc_err_q       <= '0;
            cyc_bitmap_q    <= '0;
        end else begin
            word_cnt_q      <= word_cnt_d;
            hdr_index_q     <= hdr_index_d;
            buf_q           <= buf_d;
            pkt_strobe_q    <= pkt_strobe_d;
            pkt_index_q     <= pkt_index_d;
            pkt_data_q      <= pkt_data_d;
            status_strobe_q <= status_strobe_d;
            status_code_q   <= status_code_d;
            live_good_q     <= live_good_d;
            live_err_q      <= live_err_d;
            live_bitmap_q   <= live_bitmap_d;
            cyc_good_q      <= cyc_good_d;
            cyc_err_q       <= cyc_err_d;
            cyc_bitmap_q    <= cyc_bitmap_d;
        end
    end

    assign packetStrobe     = pkt_strobe_q;
    assign packetIndex      = pkt_index_q;
    assign packetData       = pkt_data_q;
    assign statusStrobe     = status_strobe_q;
    assign statusCode       = status_code_q;
    assign cycleGoodCount   = cyc_good_q;
    assign cycleErrCount    = cyc_err_q;
    assign cycleIndexBitmap = cyc_bitmap_q;

endmodule

// File: tb/tb_fmps_test_link_reader.sv
// Bench for fmps_test_link_reader: packet-level reference model plus directed literal checks.
module tb_fmps_test_link_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        chup;
    logic        fa;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;

    logic        packetStrobe;
    logic [4:0]  packetIndex;
    logic [31:0] packetData;
    logic        statusStrobe;
    logic [1:0]  statusCode;
    logic [7:0]  cycleGoodCount;
    logic [7:0]  cycleErrCount;
    logic [31:0] cycleIndexBitmap;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fmps_test_link_reader #(
        .NUM_DATA_WORDS(1),
        .CNT_WIDTH(8),
        .INDEX_WIDTH(5)
    ) dut (
        .auroraUserClk(clk),
        .auroraReset(rst),
        .auroraChannelUp(chup),
        .auroraFAstrobe(fa),
        .RX_tdata(tdata),
        .RX_tvalid(tvalid),
        .RX_tlast(tlast),
        .packetStrobe(packetStrobe),
        .packetIndex(packetIndex),
        .packetData(packetData),
        .statusStrobe(statusStrobe),
        .statusCode(statusCode),
        .cycleGoodCount(cycleGoodCount),
        .cycleErrCount(cycleErrCount),
        .cycleIndexBitmap(cycleIndexBitmap)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level, one payload word) ----------------
    logic [31:0] pkt[$];
    bit          discarding = 0;
    bit          model_started = 0;
    bit          exp_pkt_strobe = 0;
    bit          exp_status_strobe = 0;
    int          exp_code = 0;
    int          exp_index = 0;
    logic [31:0] exp_data = '0;
    int          live_good = 0, live_err = 0, cyc_good = 0, cyc_err = 0;
    logic [31:0] live_bitmap = '0, cyc_bitmap = '0;

    always @(posedge clk) begin
        bit          ev;
        int          code;
        int          idx;
        logic [31:0] hdr;
        ev = 0;
        code = 0;
        idx = 0;
        model_started = 1;
        exp_pkt_strobe = 0;
        exp_status_strobe = 0;
        if (rst) begin
            pkt.delete();
            discarding = 0;
            exp_index = 0;
            exp_data = '0;
            live_good = 0; live_err = 0; live_bitmap = '0;
            cyc_good = 0;  cyc_err = 0;  cyc_bitmap = '0;
        end else begin
            if (!chup) begin
                pkt.delete();
                discarding = 0;
            end else if (tvalid) begin
                if (discarding) begin
                    if (tlast) discarding = 0;
                end else begin
                    pkt.push_back(tdata);
                    hdr = pkt[0];
                    if (pkt.size() == 1 && hdr[31:16] != 16'hB6CF) begin
                        ev = 1; code = 1; discarding = !tlast; pkt.delete();
                    end else if (tlast) begin
                        ev = 1;
                        code = (pkt.size() == 2) ? 0 : 2;
                        if (code == 0) begin
                            idx = int'(hdr[14:10]);
                            exp_index = idx;
                            exp_data = pkt[1];
                        end
                        pkt.delete();
                    end else if (pkt.size() == 2) begin
                        ev = 1; code = 3; discarding = 1; pkt.delete();
                    end
                end
            end
            if (fa) begin
                cyc_good = live_good; cyc_err = live_err; cyc_bitmap = live_bitmap;
                live_good = 0; live_err = 0; live_bitmap = '0;
            end
            if (ev) begin
                exp_status_strobe = 1;
                exp_code = code;
                if (code == 0) begin
                    exp_pkt_strobe = 1;
                    if (live_good < 255) live_good++;
                    live_bitmap[idx] = 1'b1;
                end else begin
                    if (live_err < 255) live_err++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_started) begin
            check("packetStrobe", 64'(packetStrobe), 64'(exp_pkt_strobe));
            check("statusStrobe", 64'(statusStrobe), 64'(exp_status_strobe));
            if (exp_status_strobe) check("statusCode", 64'(statusCode), 64'(exp_code));
            check("packetIndex", 64'(packetIndex), 64'(exp_index));
            check("packetData", 64'(packetData), 64'(exp_data));
            check("cycleGoodCount", 64'(cycleGoodCount), 64'(cyc_good));
            check("cycleErrCount", 64'(cycleErrCount), 64'(cyc_err));
            check("cycleIndexBitmap", 64'(cycleIndexBitmap), 64'(cyc_bitmap));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [31:0] d, input logic l);
        tvalid = 1'b1; tdata = d; tlast = l;
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0; tdata = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic fa_pulse();
        fa = 1'b1;
        @(posedge clk); #1;
        fa = 1'b0;
    endtask

    function automatic logic [31:0] hdr_for(input int idx);
        return 32'hB6CF0000 | (32'(idx & 31) << 10);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; chup = 1'b1; fa = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        idle(3);
        check("reset_packetStrobe", 64'(packetStrobe), 64'd0);
        check("reset_statusCode", 64'(statusCode), 64'd0);
        check("reset_packetData", 64'(packetData), 64'd0);
        check("reset_cycleBitmap", 64'(cycleIndexBitmap), 64'd0);
        rst = 1'b0;
        idle(2);

        // 1: good packet
        beat(32'hB6CF0400, 1'b0);
        beat(32'h12345678, 1'b1);
        check("t1_packetStrobe", 64'(packetStrobe), 64'd1);
        check("t1_statusCode", 64'(statusCode), 64'd0);
        check("t1_packetIndex", 64'(packetIndex), 64'd1);
        check("t1_packetData", 64'(packetData), 64'h12345678);
        idle(1);

        // 2: bad magic, trailing word drained silently
        beat(32'hDEAD0400, 1'b0);
        check("t2_statusStrobe", 64'(statusStrobe), 64'd1);
        check("t2_statusCode", 64'(statusCode), 64'd1);
        check("t2_packetStrobe", 64'(packetStrobe), 64'd0);
        beat(32'h0BADF00D, 1'b1);
        check("t2_drain_quiet", 64'(statusStrobe), 64'd0);
        fa_pulse();
        check("t2_cycleErrCount", 64'(cycleErrCount), 64'd1);
        check("t2_cycleGoodCount", 64'(cycleGoodCount), 64'd1);
        check("t2_cycleBitmap", 64'(cycleIndexBitmap), 64'h2);

        // 3: short (header only) and long (extra word) packets
        beat(32'hB6CF0400, 1'b1);
        check("t3_short_code", 64'(statusCode), 64'd2);
        beat(32'hB6CF0800, 1'b0);
        beat(32'hAAAA5555, 1'b0);
        check("t3_long_strobe", 64'(statusStrobe), 64'd1);
        check("t3_long_code", 64'(statusCode), 64'd3);
        beat(32'h5555AAAA, 1'b1);
        check("t3_third_ignored", 64'(statusStrobe), 64'd0);
        check("t3_data_held", 64'(packetData), 64'h12345678);

        // 4: eight good packets with indices 0..7
        fa_pulse();
        check("t4_prev_err", 64'(cycleErrCount), 64'd2);
        for (int i = 0; i < 8; i++) begin
            beat(hdr_for(i), 1'b0);
            beat(32'h1000_0000 + 32'(i), 1'b1);
        end
        fa_pulse();
        check("t4_cycleGoodCount", 64'(cycleGoodCount), 64'd8);
        check("t4_cycleBitmap", 64'(cycleIndexBitmap), 64'h000000FF);
        check("t4_cycleErrCount", 64'(cycleErrCount), 64'd0);

        // 5a: good packet decided in the same cycle as the FA strobe
        beat(hdr_for(9), 1'b0);
        fa = 1'b1;
        beat(32'hCAFEF00D, 1'b1);
        fa = 1'b0;
        check("t5_strobe", 64'(packetStrobe), 64'd1);
        check("t5_old_cycle_good", 64'(cycleGoodCount), 64'd0);
        fa_pulse();
        check("t5_new_cycle_good", 64'(cycleGoodCount), 64'd1);
        check("t5_new_cycle_bitmap", 64'(cycleIndexBitmap), 64'h00000200);

        // 5b: channel drop mid-packet, including a beat offered while down
        beat(hdr_for(3), 1'b0);
        chup = 1'b0;
        beat(32'h11111111, 1'b1);
        check("t5_drop_quiet", 64'(statusStrobe), 64'd0);
        chup = 1'b1;
        idle(1);
        beat(hdr_for(4), 1'b0);
        beat(32'h44444444, 1'b1);
        check("t5_after_drop_idx", 64'(packetIndex), 64'd4);

        // Counter saturation
        fa_pulse();
        for (int i = 0; i < 260; i++) begin
            beat(hdr_for(31), 1'b0);
            beat(32'(i), 1'b1);
        end
        fa_pulse();
        check("sat_cycleGoodCount", 64'(cycleGoodCount), 64'd255);
        check("sat_cycleBitmap", 64'(cycleIndexBitmap), 64'h80000000);

        // 6: random tvalid gaps over 100 packets
        for (int p = 0; p < 100; p++) begin
            for (int g = 0; g < 6; g++) begin
                if ($urandom_range(1, 0) == 0) break;
                idle(1);
            end
            beat(hdr_for(p), 1'b0);
            for (int g = 0; g < 6; g++) begin
                if ($urandom_range(1, 0) == 0) break;
                idle(1);
            end
            beat($urandom, 1'b1);
        end
        idle(2);
        fa_pulse();
        check("t6_cycleGoodCount", 64'(cycleGoodCount), 64'd100);
        check("t6_cycleErrCount", 64'(cycleErrCount), 64'd0);
        check("t6_cycleBitmap", 64'(cycleIndexBitmap), 64'hFFFFFFFF);

        // Reset arriving mid-packet drops it without a strobe
        beat(hdr_for(5), 1'b0);
        rst = 1'b1;
        beat(32'h55555555, 1'b1);
        check("rst_mid_pktStrobe", 64'(packetStrobe), 64'd0);
        check("rst_mid_statusStrobe", 64'(statusStrobe), 64'd0);
        check("rst_mid_packetData", 64'(packetData), 64'd0);
        rst = 1'b0;
        idle(2);
        beat(hdr_for(6), 1'b0);
        beat(32'h66666666, 1'b1);
        check("post_rst_data", 64'(packetData), 64'h66666666);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
